// File: rtl/mc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_pkg
// Purpose  : Shared types and helpers for the mc_mem_bridge memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package mc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_e;

    localparam int MEM_DATA_W = 32;
    localparam int BE_W       = MEM_DATA_W / 8;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Round-robin pick: a tie goes to the port that was not granted last.
    function automatic port_e rr_pick(input logic if_v, input logic dm_v, input port_e last);
        if (if_v && dm_v) begin
            return (last == PORT_IF) ? PORT_DM : PORT_IF;
        end
        return dm_v ? PORT_DM : PORT_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_bridge_if
// Purpose  : Fetch and data request/response channels of the memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_mem_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req_valid;
    logic                  dm_req_ready;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_be;
    logic                  dm_rsp_valid;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  busy;

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output dm_req_valid, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_req_ready, dm_rsp_valid, dm_rdata,
        input  busy
    );

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  dm_req_valid, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_req_ready, dm_rsp_valid, dm_rdata,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/mc_mem_ram.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_ram
// Purpose  : Single-port synchronous RAM (DEPTH x DATA_W), byte write enables.
// Revision : 1.0 - initial release
// ============================================================================
module mc_mem_ram
    import mc_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  wire logic                      clk,
    input  wire logic                      en_i,
    input  wire logic                      we_i,
    input  wire logic [AW-1:0]             addr_i,
    input  wire logic [DATA_W-1:0]         wdata_i,
    input  wire logic [be_width(DATA_W)-1:0] be_i,
    output logic      [DATA_W-1:0]         rdata_o
);
    localparam int NB = be_width(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset; rdata_q is only observed when gated.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mc_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_bridge
// Purpose  : Round-robin fetch/data bridge onto one RAM with wait states.
//            MC_MEM_BYTE_STROBE_EN enables per-byte writes from dm_be.
// Revision : 1.0 - initial release
// ============================================================================
module mc_mem_bridge
    import mc_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mc_mem_bridge_if.slave bus
);
    localparam int          NB       = be_width(DATA_W);
    localparam int          RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e              state_q, state_d;
    port_e               last_q, last_d;
    port_e               port_q, port_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic                oor_q, oor_d;
    logic [3:0]          cnt_q, cnt_d;

    port_e               w_grant;
    logic                w_accept;
    logic                w_commit;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_we;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [NB-1:0]       w_sel_be;
    logic [NB-1:0]       w_ram_be;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_rsp;

    assign w_grant  = rr_pick(bus.if_req_valid, bus.dm_req_valid, last_q);
    assign w_accept = (state_q == IDLE) && (bus.if_req_valid || bus.dm_req_valid) && !reset;

    assign bus.if_req_ready = w_accept && (w_grant == PORT_IF);
    assign bus.dm_req_ready = w_accept && (w_grant == PORT_DM);

    // In IDLE the RAM sees the live request so a zero-wait access commits on the accept edge.
    always_comb begin
        w_sel_addr  = addr_q;
        w_sel_we    = we_q;
        w_sel_wdata = wdata_q;
        w_sel_be    = be_q;
        if (state_q == IDLE) begin
            w_sel_addr  = (w_grant == PORT_DM) ? bus.dm_addr : bus.if_addr;
            w_sel_we    = (w_grant == PORT_DM) && bus.dm_we;
            w_sel_wdata = bus.dm_wdata;
            w_sel_be    = bus.dm_be;
        end
    end

    assign w_in_range = 32'(w_sel_addr) < 32'(DEPTH);
    assign w_commit   = ((state_q == ACCESS) && (cnt_q == 4'd0)) ||
                        ((state_q == IDLE) && w_accept && (WAIT_STATES == 0));

`ifdef MC_MEM_BYTE_STROBE_EN
    assign w_ram_be = w_sel_be;
`else
    // Strobes are ignored: every write stores the full word.
    assign w_ram_be = w_sel_be | '1;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        oor_d   = oor_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    port_d  = w_grant;
                    last_d  = w_grant;
                    addr_d  = w_sel_addr;
                    we_d    = w_sel_we;
                    wdata_d = bus.dm_wdata;
                    be_d    = bus.dm_be;
                    oor_d   = !w_in_range;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_STATES > 0) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= PORT_IF;
            port_q  <= PORT_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            oor_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            oor_q   <= oor_d;
            cnt_q   <= cnt_d;
        end
    end

    mc_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (w_commit && w_in_range),
        .we_i    (w_sel_we),
        .addr_i  (w_sel_addr[RAM_AW-1:0]),
        .wdata_i (w_sel_wdata),
        .be_i    (w_ram_be),
        .rdata_o (w_ram_rdata)
    );

    // Write acks and out-of-range reads return zero.
    assign w_rsp   = (state_q == RESP);
    assign w_rdata = (w_rsp && !we_q && !oor_q) ? w_ram_rdata : '0;

    assign bus.if_rsp_valid = w_rsp && (port_q == PORT_IF);
    assign bus.dm_rsp_valid = w_rsp && (port_q == PORT_DM);
    assign bus.if_rdata     = (port_q == PORT_IF) ? w_rdata : '0;
    assign bus.dm_rdata     = (port_q == PORT_DM) ? w_rdata : '0;
    assign bus.busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mc_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_mem_bridge
// Purpose  : Scoreboard bench for mc_mem_bridge (WAIT_STATES=2 and WAIT_STATES=0/DEPTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_mem_bridge;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mc_mem_bridge_if #(.DATA_W(32), .ADDR_W(6)) ifa ();
    mc_mem_bridge_if #(.DATA_W(32), .ADDR_W(6)) ifb ();

    mc_mem_bridge #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .WAIT_STATES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    mc_mem_bridge #(.DATA_W(32), .ADDR_W(6), .DEPTH(32), .WAIT_STATES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa_if[$];
    exp_t qa_dm[$];
    exp_t qb_if[$];
    exp_t qb_dm[$];
    bit   glog[$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endfunction

    function automatic void unexpected(input string name);
        n_chk++;
        $display("FAIL %s_unexpected: rsp_valid=1 with no request outstanding (required 0)", name);
    endfunction

    function automatic void cmp_rsp(input string name, input exp_t e, input logic [31:0] data);
        check({name, "_data"}, data, e.data);
        check({name, "_cycle"}, 32'(cyc), 32'(e.cyc));
    endfunction

    // Monitor: pops expectations whenever a response pulse is seen.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifa.if_rsp_valid) begin
                if (qa_if.size() == 0) unexpected("a_if"); else cmp_rsp("a_if", qa_if.pop_front(), ifa.if_rdata);
            end
            if (ifa.dm_rsp_valid) begin
                if (qa_dm.size() == 0) unexpected("a_dm"); else cmp_rsp("a_dm", qa_dm.pop_front(), ifa.dm_rdata);
            end
            if (ifb.if_rsp_valid) begin
                if (qb_if.size() == 0) unexpected("b_if"); else cmp_rsp("b_if", qb_if.pop_front(), ifb.if_rdata);
            end
            if (ifb.dm_rsp_valid) begin
                if (qb_dm.size() == 0) unexpected("b_dm"); else cmp_rsp("b_dm", qb_dm.pop_front(), ifb.dm_rdata);
            end
            if (ifa.if_req_valid && ifa.if_req_ready) glog.push_back(1'b0);
            if (ifa.dm_req_valid && ifa.dm_req_ready) glog.push_back(1'b1);
        end
    end

    function automatic void timeout(input string name);
        n_chk++;
        $display("FAIL %s_accept: ready=0 after 100 cycles, required ready=1", name);
    endfunction

    task automatic a_if_read(input logic [5:0] addr, input logic [31:0] exp);
        int n = 0;
        ifa.if_addr      = addr;
        ifa.if_req_valid = 1'b1;
        @(negedge clk);
        while (!ifa.if_req_ready && n < 100) begin @(negedge clk); n++; end
        if (!ifa.if_req_ready) timeout("a_if");
        else qa_if.push_back('{exp, cyc + 3});
        @(posedge clk); #1;
        ifa.if_req_valid = 1'b0;
    endtask

    task automatic a_dm(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp);
        int n = 0;
        ifa.dm_we        = we;
        ifa.dm_addr      = addr;
        ifa.dm_wdata     = wd;
        ifa.dm_be        = be;
        ifa.dm_req_valid = 1'b1;
        @(negedge clk);
        while (!ifa.dm_req_ready && n < 100) begin @(negedge clk); n++; end
        if (!ifa.dm_req_ready) timeout("a_dm");
        else qa_dm.push_back('{exp, cyc + 3});
        @(posedge clk); #1;
        ifa.dm_req_valid = 1'b0;
    endtask

    task automatic b_if_read(input logic [5:0] addr, input logic [31:0] exp, output int acc);
        int n = 0;
        acc              = 0;
        ifb.if_addr      = addr;
        ifb.if_req_valid = 1'b1;
        @(negedge clk);
        while (!ifb.if_req_ready && n < 100) begin @(negedge clk); n++; end
        if (!ifb.if_req_ready) timeout("b_if");
        else begin
            acc = cyc;
            qb_if.push_back('{exp, cyc + 1});
        end
        @(posedge clk); #1;
        ifb.if_req_valid = 1'b0;
    endtask

    task automatic b_dm(input logic we, input logic [5:0] addr, input logic [31:0] wd, input logic [31:0] exp);
        int n = 0;
        ifb.dm_we        = we;
        ifb.dm_addr      = addr;
        ifb.dm_wdata     = wd;
        ifb.dm_be        = 4'hF;
        ifb.dm_req_valid = 1'b1;
        @(negedge clk);
        while (!ifb.dm_req_ready && n < 100) begin @(negedge clk); n++; end
        if (!ifb.dm_req_ready) timeout("b_dm");
        else qb_dm.push_back('{exp, cyc + 1});
        @(posedge clk); #1;
        ifb.dm_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa_if.size() + qa_dm.size() + qb_if.size() + qb_dm.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_ctl"}, 32'({ifa.if_req_ready, ifa.dm_req_ready, ifa.if_rsp_valid, ifa.dm_rsp_valid, ifa.busy}), 32'h0);
        check({tag, "_a_if_rdata"}, ifa.if_rdata, 32'h0);
        check({tag, "_a_dm_rdata"}, ifa.dm_rdata, 32'h0);
        check({tag, "_b_ctl"}, 32'({ifb.if_req_ready, ifb.dm_req_ready, ifb.if_rsp_valid, ifb.dm_rsp_valid, ifb.busy}), 32'h0);
        check({tag, "_b_if_rdata"}, ifb.if_rdata, 32'h0);
        check({tag, "_b_dm_rdata"}, ifb.dm_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          prev_acc;
        int          n;
        logic [31:0] exp_bs;

        ifa.if_req_valid = 1'b1; ifa.if_addr = '0;
        ifa.dm_req_valid = 1'b1; ifa.dm_we = 1'b0; ifa.dm_addr = '0; ifa.dm_wdata = '0; ifa.dm_be = '0;
        ifb.if_req_valid = 1'b1; ifb.if_addr = '0;
        ifb.dm_req_valid = 1'b1; ifb.dm_we = 1'b0; ifb.dm_addr = '0; ifb.dm_wdata = '0; ifb.dm_be = '0;

        // Reset state, with requests pending so ready must still be held low.
        repeat (2) @(negedge clk);
        check_zero("reset");
        ifa.if_req_valid = 1'b0; ifa.dm_req_valid = 1'b0;
        ifb.if_req_valid = 1'b0; ifb.dm_req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Contention from reset: data wins the first tie, then strict alternation.
        fork
            for (int i = 0; i < 10; i++) a_dm(1'b1, 6'(10 + i), 32'hC0DE_0000 + 32'(i), 4'hF, 32'h0);
            for (int i = 0; i < 10; i++) a_if_read(6'(10 + i), 32'hC0DE_0000 + 32'(i));
        join
        drain();
        check("grant_count", 32'(glog.size()), 32'd20);
        n = (glog.size() < 20) ? glog.size() : 20;
        for (int i = 0; i < n; i++) check($sformatf("grant_%0d", i), 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

        // WAIT_STATES=2 write then fetch of the same word.
        a_dm(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 32'h0);
        a_if_read(6'd5, 32'hDEADBEEF);
        drain();

        // Byte strobes.
`ifdef MC_MEM_BYTE_STROBE_EN
        exp_bs = 32'h00BB00DD;
`else
        exp_bs = 32'hAABBCCDD;
`endif
        a_dm(1'b1, 6'd20, 32'h0000_0000, 4'hF, 32'h0);
        a_dm(1'b1, 6'd20, 32'hAABBCCDD, 4'b0101, 32'h0);
        a_if_read(6'd20, exp_bs);
        drain();

        // Reset during ACCESS of a write aborts it.
        a_dm(1'b1, 6'd7, 32'h11111111, 4'hF, 32'h0);
        a_if_read(6'd7, 32'h11111111);
        drain();
        ifa.dm_we = 1'b1; ifa.dm_addr = 6'd7; ifa.dm_wdata = 32'h22222222; ifa.dm_be = 4'hF;
        ifa.dm_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ifa.dm_req_ready && n < 100) begin @(negedge clk); n++; end
        if (!ifa.dm_req_ready) timeout("abort_dm");
        @(posedge clk); #1;
        ifa.dm_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        a_if_read(6'd7, 32'h11111111);
        drain();

        // WAIT_STATES=0: preload then back-to-back fetches, one response every second cycle.
        for (int i = 0; i < 4; i++) b_dm(1'b1, 6'(i), 32'h1000_0000 + 32'(i * 17), 32'h0);
        drain();
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            b_if_read(6'(i), 32'h1000_0000 + 32'(i * 17), acc);
            if (i > 0) check($sformatf("b_spacing_%0d", i), 32'(acc - prev_acc), 32'd2);
            prev_acc = acc;
        end
        drain();

        // DEPTH=32: address 40 reads 0, a write there is dropped but acked.
        b_dm(1'b1, 6'd8, 32'h88888888, 32'h0);
        b_if_read(6'd40, 32'h0, acc);
        b_dm(1'b1, 6'd40, 32'hFFFFFFFF, 32'h0);
        b_if_read(6'd8, 32'h88888888, acc);
        b_dm(1'b0, 6'd40, 32'h0, 32'h0);
        b_dm(1'b0, 6'd8, 32'h0, 32'h88888888);
        drain();

        check("queues_empty", 32'(qa_if.size() + qa_dm.size() + qb_if.size() + qb_dm.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_mem_bridge.md
# mc_mem_bridge

Parametrised memory bridge for the multicycle MIPS core: one word-addressed backing RAM shared by the instruction-fetch port and the data port, with valid/ready request handshakes, programmable wait states, and round-robin arbitration. It replaces the fixed instruction-memory and data-memory signal bundle the bench currently drives directly. The bench now sees real access latency and contention, where the old bundle had zero-latency memories.

## Interface
- DATA_W, 32, data word width (multiple of 8)
- ADDR_W, 6, word-address width
- DEPTH, 64, implemented words (≤ 2**ADDR_W)
- WAIT_STATES, 2, extra cycles per access (0..15)
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch word address
- if_rsp_valid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetched instruction
- dm_req_valid  in  1  data request
- dm_req_ready  out  1  data request accepted this cycle
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  write data
- dm_be  in  DATA_W/8  byte strobes (used only with MC_MEM_BYTE_STROBE_EN)
- dm_rsp_valid  out  1  read data / write ack, one-cycle pulse
- dm_rdata  out  DATA_W  read data (0 on write ack)
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: the grant goes to the requesting port.
  - On a tie, the grant goes to the port not granted last. last_grant resets to IF, so data wins the first tie.
  - The granted port's req_ready is high combinationally in the same cycle. The transfer occurs on the edge where valid & ready are both high.
  - On transfer, the bridge latches port, addr, we, wdata and be.
  - Next state is ACCESS if WAIT_STATES > 0, else RESP.
- ACCESS: the wait counter loads WAIT_STATES-1 and decrements each cycle. At 0 the FSM moves to RESP.
- RESP: the granted port's rsp_valid is high for exactly one cycle, and rdata is registered. The FSM returns to IDLE.
- The ungranted port's ready stays 0 whenever state ≠ IDLE.
- Read data is sampled from the RAM on the transition into RESP.
- Writes commit to the RAM on the transition into RESP. The ack is dm_rsp_valid with dm_rdata = 0.
- If addr ≥ DEPTH: a read returns 0, a write is dropped, and the ack is still issued.
- RAM contents are not reset. All other state is reset.
- Requesters must hold valid/addr/data stable until ready. The bridge does not check this.

## Timing
- Reset values: if_req_ready = 0, dm_req_ready = 0, if_rsp_valid = 0, dm_rsp_valid = 0, if_rdata = 0, dm_rdata = 0, busy = 0. State resets to IDLE and last_grant to IF.
- Latency is WAIT_STATES+1 cycles from the accept edge to the rsp_valid cycle.
  - WAIT_STATES=0: the response appears in the cycle after accept.
- Throughput: one access per WAIT_STATES+2 cycles. The next accept is the cycle after rsp_valid.
- Reset asserted mid-access aborts the access: no response and no write commit. ACCESS is before the commit edge.
- A request arriving while busy waits. It is served in the next IDLE cycle per round-robin.

## Configuration
- MC_MEM_BYTE_STROBE_EN defined: a write updates only the bytes whose dm_be bit is 1. dm_be = 0 writes nothing but still acks.
- Not defined: dm_be is ignored and every write stores the full word.

## Structure
- Package mc_mem_pkg holds:
  - typedef state_e {IDLE, ACCESS, RESP}
  - typedef port_e {PORT_IF, PORT_DM}
  - localparam BE_W = DATA_W/8
- Sub-module mc_mem_ram: a single-port synchronous RAM (DEPTH × DATA_W) with optional byte write enables. The FSM and arbiter stay in mc_mem_bridge.

## Test plan
- WAIT_STATES=2, DM write addr 5 = 0xDEADBEEF, then IF read addr 5:
  - write ack 3 cycles after accept
  - if_rdata = 0xDEADBEEF, 3 cycles after its accept
- Both valid in the same IDLE cycle, repeatedly:
  - grants alternate DM, IF, DM, IF
  - no starvation over 20 requests
- WAIT_STATES=0 back-to-back IF reads at addresses 0..3: a response each second cycle, data matches preload.
- Reset asserted during ACCESS of a DM write to addr 7 (old value 0x11111111):
  - no rsp_valid
  - addr 7 reads back 0x11111111
  - all outputs are 0 during reset
- DEPTH=32, read addr 40 returns 0; write addr 40 acks and RAM is unchanged.
- With MC_MEM_BYTE_STROBE_EN: write 0xAABBCCDD with be=4'b0101 over 0x00000000, read back 0x00BB00DD. Without the macro, the same write reads back 0xAABBCCDD.
